// File: rtl/alu_compare_unit_pkg.sv
// ---------------------------------------------------------------------------
// riscv_alu_pkg
// Shared definitions for the RV32I execute-stage ALU/compare unit:
//   XLEN_DEFAULT  - datapath width (only 32 is supported)
//   alu_op_e      - 4-bit ALU operation code
//   F3_*          - branch funct3 condition codes
// ---------------------------------------------------------------------------
package riscv_alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_compare_unit_if.sv
// ---------------------------------------------------------------------------
// alu_compare_unit_if
// Groups the operand, control and result signals of alu_compare_unit.
//   master : the surrounding execute logic (drives operands, reads results)
//   slave  : the ALU/compare unit itself
// Signals:
//   valid_in, alu_in1, alu_in2, alu_op, cmp_in1, cmp_in2, funct3  (to unit)
//   result, cond            combinational outputs
//   result_q, cond_q, valid_q  registered outputs for EX/MEM
// ---------------------------------------------------------------------------
interface alu_compare_unit_if #(
    parameter int XLEN = riscv_alu_pkg::XLEN_DEFAULT
);

    logic            valid_in;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] cmp_in1;
    logic [XLEN-1:0] cmp_in2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] result;
    logic            cond;
    logic [XLEN-1:0] result_q;
    logic            cond_q;
    logic            valid_q;

    modport master (
        output valid_in, alu_in1, alu_in2, alu_op, cmp_in1, cmp_in2, funct3,
        input  result, cond, result_q, cond_q, valid_q
    );

    modport slave (
        input  valid_in, alu_in1, alu_in2, alu_op, cmp_in1, cmp_in2, funct3,
        output result, cond, result_q, cond_q, valid_q
    );

endinterface

// File: rtl/alu_compare_unit_branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Purely combinational RV32I branch comparator.
// Ports:
//   cmp_in1, cmp_in2 : forwarded rs1/rs2 values
//   funct3           : branch condition select (F3_*)
//   cond             : 1 when the selected condition holds; 0 for the
//                      unused encodings 010/011
// ---------------------------------------------------------------------------
module branch_cmp
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] cmp_in1,
    input  logic [XLEN-1:0] cmp_in2,
    input  logic [2:0]      funct3,
    output logic            cond
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (cmp_in1 == cmp_in2);
    assign lt_s = ($signed(cmp_in1) < $signed(cmp_in2));
    assign lt_u = (cmp_in1 < cmp_in2);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = !lt_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_compare_unit.sv
// ---------------------------------------------------------------------------
// alu_compare_unit
// RV32I execute-stage arithmetic core: integer ALU plus branch comparator.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears the registered outputs only)
//   bus   : alu_compare_unit_if.slave carrying operands, alu_op, funct3,
//           valid_in, the combinational result/cond and the registered
//           result_q/cond_q/valid_q copies for the EX/MEM register.
// ---------------------------------------------------------------------------
module alu_compare_unit
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_compare_unit_if.slave   bus
);

    logic [XLEN-1:0] alu_result;
    logic            cmp_cond;
    logic [4:0]      shamt;

    // Only the low five bits of operand B select a shift amount.
    assign shamt = bus.alu_in2[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_op_e'(bus.alu_op))
            ALU_ADD:    alu_result = bus.alu_in1 + bus.alu_in2;
            ALU_SUB:    alu_result = bus.alu_in1 - bus.alu_in2;
            ALU_SLL:    alu_result = bus.alu_in1 << shamt;
            ALU_SLT:    alu_result = {{(XLEN-1){1'b0}},
                                      ($signed(bus.alu_in1) < $signed(bus.alu_in2))};
            ALU_SLTU:   alu_result = {{(XLEN-1){1'b0}}, (bus.alu_in1 < bus.alu_in2)};
            ALU_XOR:    alu_result = bus.alu_in1 ^ bus.alu_in2;
            ALU_SRL:    alu_result = bus.alu_in1 >> shamt;
            ALU_SRA:    alu_result = $unsigned($signed(bus.alu_in1) >>> shamt);
            ALU_OR:     alu_result = bus.alu_in1 | bus.alu_in2;
            ALU_AND:    alu_result = bus.alu_in1 & bus.alu_in2;
            ALU_PASS_B: alu_result = bus.alu_in2;
            default:    alu_result = '0;
        endcase
    end

    branch_cmp #(
        .XLEN (XLEN)
    ) u_branch_cmp (
        .cmp_in1 (bus.cmp_in1),
        .cmp_in2 (bus.cmp_in2),
        .funct3  (bus.funct3),
        .cond    (cmp_cond)
    );

    assign bus.result = alu_result;
    assign bus.cond   = cmp_cond;

    // Results are captured every cycle regardless of valid_in; downstream
    // logic qualifies them with valid_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result_q <= '0;
            bus.cond_q   <= 1'b0;
            bus.valid_q  <= 1'b0;
        end else begin
            bus.result_q <= alu_result;
            bus.cond_q   <= cmp_cond;
            bus.valid_q  <= bus.valid_in;
        end
    end

endmodule

// File: tb/tb_alu_compare_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_compare_unit
// Directed self-checking bench for alu_compare_unit. Inputs change on the
// falling clock edge; combinational outputs are sampled 1 ns later and the
// registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_alu_compare_unit;
    import riscv_alu_pkg::*;

    logic clk;
    logic rst_n;
    int   testCount;
    int   failCount;

    alu_compare_unit_if #(.XLEN(32)) bus ();

    alu_compare_unit #(
        .XLEN (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one full set of inputs on the falling edge, then settle.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [31:0] c1,
                                 input logic [31:0] c2, input logic [2:0] f3);
        @(negedge clk);
        bus.valid_in = v;
        bus.alu_in1  = a;
        bus.alu_in2  = b;
        bus.alu_op   = op;
        bus.cmp_in1  = c1;
        bus.cmp_in2  = c2;
        bus.funct3   = f3;
        #1;
    endtask

    task automatic waitRegistered();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n        = 1'b0;
        bus.valid_in = 1'b1;
        bus.alu_in1  = 32'h1;
        bus.alu_in2  = 32'h1;
        bus.alu_op   = 4'd0;
        bus.cmp_in1  = 32'h0;
        bus.cmp_in2  = 32'h0;
        bus.funct3   = F3_BEQ;

        // Reset holds registers at zero even across clock edges.
        waitRegistered();
        waitRegistered();
        checkOutput("rst_result_q", bus.result_q, 32'h0);
        checkOutput("rst_cond_q", {31'b0, bus.cond_q}, 32'h0);
        checkOutput("rst_valid_q", {31'b0, bus.valid_q}, 32'h0);
        checkOutput("rst_comb_result", bus.result, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU wrap-around and first registered capture
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 32'h0, 32'h0, F3_BEQ);
        checkOutput("add_wrap", bus.result, 32'h8000_0000);
        waitRegistered();
        checkOutput("add_result_q", bus.result_q, 32'h8000_0000);
        checkOutput("add_cond_q", {31'b0, bus.cond_q}, 32'h1);
        checkOutput("add_valid_q", {31'b0, bus.valid_q}, 32'h1);

        applyStimulus(1'b0, 32'h0000_0000, 32'h0000_0001, 4'd1, 32'h1, 32'h2, F3_BEQ);
        checkOutput("sub_wrap", bus.result, 32'hFFFF_FFFF);
        waitRegistered();
        checkOutput("sub_result_q", bus.result_q, 32'hFFFF_FFFF);
        checkOutput("sub_cond_q", {31'b0, bus.cond_q}, 32'h0);
        checkOutput("sub_valid_q", {31'b0, bus.valid_q}, 32'h0);

        // Shifts ignore in2[31:5]
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0024, 4'd7, 32'h0, 32'h0, F3_BEQ);
        checkOutput("sra", bus.result, 32'hF800_0000);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0024, 4'd6, 32'h0, 32'h0, F3_BEQ);
        checkOutput("srl", bus.result, 32'h0800_0000);
        applyStimulus(1'b1, 32'h0000_0001, 32'h0000_001F, 4'd2, 32'h0, 32'h0, F3_BEQ);
        checkOutput("sll31", bus.result, 32'h8000_0000);
        applyStimulus(1'b1, 32'h0000_0001, 32'hFFFF_FFE3, 4'd2, 32'h0, 32'h0, F3_BEQ);
        checkOutput("sll_upper_ignored", bus.result, 32'h0000_0008);

        // Set-less-than, logic ops, pass-through, unused codes
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'h0, 32'h0, F3_BEQ);
        checkOutput("slt", bus.result, 32'h1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 32'h0, 32'h0, F3_BEQ);
        checkOutput("sltu", bus.result, 32'h0);
        applyStimulus(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd5, 32'h0, 32'h0, F3_BEQ);
        checkOutput("xor", bus.result, 32'hFF00_ED34);
        applyStimulus(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd8, 32'h0, 32'h0, F3_BEQ);
        checkOutput("or", bus.result, 32'hFFF0_FF34);
        applyStimulus(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd9, 32'h0, 32'h0, F3_BEQ);
        checkOutput("and", bus.result, 32'h00F0_1200);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5000, 4'd10, 32'h0, 32'h0, F3_BEQ);
        checkOutput("pass_b", bus.result, 32'h1234_5000);
        for (int op = 11; op < 16; op++) begin
            applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5000, op[3:0], 32'h0, 32'h0, F3_BEQ);
            checkOutput($sformatf("op%0d_zero", op), bus.result, 32'h0);
        end

        // Branch conditions on -1 vs 1
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, F3_BLT);
        checkOutput("blt", {31'b0, bus.cond}, 32'h1);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, F3_BGE);
        checkOutput("bge", {31'b0, bus.cond}, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, F3_BLTU);
        checkOutput("bltu", {31'b0, bus.cond}, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, F3_BGEU);
        checkOutput("bgeu", {31'b0, bus.cond}, 32'h1);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, F3_BEQ);
        checkOutput("beq_ne", {31'b0, bus.cond}, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, F3_BEQ);
        checkOutput("beq_eq", {31'b0, bus.cond}, 32'h1);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, F3_BNE);
        checkOutput("bne_eq", {31'b0, bus.cond}, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b010);
        checkOutput("f3_010", {31'b0, bus.cond}, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'h0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b011);
        checkOutput("f3_011", {31'b0, bus.cond}, 32'h0);

        // Asynchronous reset between edges discards the captured result
        applyStimulus(1'b1, 32'h0000_1234, 32'h0, 4'd0, 32'h7, 32'h7, F3_BEQ);
        waitRegistered();
        checkOutput("pre_rst_result_q", bus.result_q, 32'h0000_1234);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_result_q", bus.result_q, 32'h0);
        checkOutput("async_rst_cond_q", {31'b0, bus.cond_q}, 32'h0);
        checkOutput("async_rst_valid_q", {31'b0, bus.valid_q}, 32'h0);
        applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0006, 4'd0, 32'h1, 32'h2, F3_BNE);
        checkOutput("rst_comb_unaffected", bus.result, 32'h0000_000B);
        waitRegistered();
        checkOutput("rst_hold_result_q", bus.result_q, 32'h0);
        checkOutput("rst_hold_valid_q", {31'b0, bus.valid_q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        waitRegistered();
        checkOutput("post_rst_result_q", bus.result_q, 32'h0000_000B);
        checkOutput("post_rst_cond_q", {31'b0, bus.cond_q}, 32'h1);
        checkOutput("post_rst_valid_q", {31'b0, bus.valid_q}, 32'h1);

        // Back-to-back ops with valid_in 1,0,1
        applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0003, 4'd1, 32'h0, 32'h0, F3_BEQ);
        waitRegistered();
        checkOutput("b2b0_result_q", bus.result_q, 32'h0000_000D);
        checkOutput("b2b0_valid_q", {31'b0, bus.valid_q}, 32'h1);
        applyStimulus(1'b0, 32'h0000_00F0, 32'h0000_000F, 4'd8, 32'h0, 32'h1, F3_BEQ);
        waitRegistered();
        checkOutput("b2b1_result_q", bus.result_q, 32'h0000_00FF);
        checkOutput("b2b1_valid_q", {31'b0, bus.valid_q}, 32'h0);
        checkOutput("b2b1_cond_q", {31'b0, bus.cond_q}, 32'h0);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 4'd7, 32'h5, 32'h5, F3_BGEU);
        waitRegistered();
        checkOutput("b2b2_result_q", bus.result_q, 32'hC000_0000);
        checkOutput("b2b2_valid_q", {31'b0, bus.valid_q}, 32'h1);
        checkOutput("b2b2_cond_q", {31'b0, bus.cond_q}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_compare_unit.md
Name: alu_compare_unit

Overview:
RV32I execute-stage arithmetic core. It combines the integer ALU (operation selected by alu_op) with the branch comparator (condition selected by the branch funct3). It drives combinational results for same-cycle use: jump/branch target, PC redirect decision, bypass. It also drives a registered copy that feeds the EX/MEM pipeline register. Operand selection (PC/imm/forwarding) is done by the surrounding execute logic, not here.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  current operation is valid (pipeline valid bit)
alu_in1  input  XLEN  ALU operand A (rs1 or PC, already selected)
alu_in2  input  XLEN  ALU operand B (rs2 or sign-extended imm, already selected)
alu_op  input  4  ALU operation code (alu_op_e)
cmp_in1  input  XLEN  comparator operand (forwarded rs1 value)
cmp_in2  input  XLEN  comparator operand (forwarded rs2 value)
funct3  input  3  branch condition select
result  output  XLEN  combinational ALU result
cond  output  1  combinational branch condition
result_q  output  XLEN  result registered on clk
cond_q  output  1  cond registered on clk
valid_q  output  1  valid_in registered on clk

Behaviour:
- Combinational path, 0-cycle latency: result and cond depend only on the current inputs, with no internal state.
- alu_op encoding:
  - 0 ADD: in1+in2, mod 2^32
  - 1 SUB: in1-in2, mod 2^32
  - 2 SLL: in1 << in2[4:0]
  - 3 SLT: signed in1<in2 ? 1 : 0
  - 4 SLTU: unsigned in1<in2 ? 1 : 0
  - 5 XOR
  - 6 SRL: logical in1 >> in2[4:0]
  - 7 SRA: arithmetic in1 >>> in2[4:0]
  - 8 OR
  - 9 AND
  - 10 PASS_B: result=in2 (LUI)
  - 11-15: result=0
- Shifts use only in2[4:0]; in2[31:5] are ignored.
- Overflow is never flagged; results wrap.
- funct3 encoding for cond:
  - 000 BEQ: in1==in2
  - 001 BNE: in1!=in2
  - 100 BLT: signed <
  - 101 BGE: signed >=
  - 110 BLTU: unsigned <
  - 111 BGEU: unsigned >=
  - 010/011: cond=0
- Registered path, 1-cycle latency: at each rising clk, result_q<=result, cond_q<=cond and valid_q<=valid_in.
- result_q and cond_q capture every cycle regardless of valid_in. Consumers qualify them with valid_q.
- Reset: when rst_n=0, result_q=0, cond_q=0 and valid_q=0 immediately (asynchronous). Registers hold reset while rst_n is low and resume capture on the first rising clk after rst_n deasserts.
- Reset does not affect the combinational outputs.
- Reset asserted mid-operation discards the in-flight registered result.
- No X propagation: every alu_op and funct3 value produces a defined output.

Decomposition:
- Shared package riscv_alu_pkg holds:
  - alu_op_e, a 4-bit enum with the codes above
  - branch funct3 localparams F3_BEQ..F3_BGEU
  - XLEN default
- Sub-module branch_cmp (the comparator: cmp_in1, cmp_in2, funct3 -> cond) is instantiated once.
- ALU case logic and output registers live in the top.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> result=0x80000000. SUB 0x00000000-0x00000001 -> 0xFFFFFFFF. One clk later, result_q matches and valid_q=valid_in.
- SRA 0x80000000 by in2=0x00000024 (shamt 4) -> 0xF8000000. SRL same -> 0x08000000. SLL 0x1 by 31 -> 0x80000000.
- SLT 0xFFFFFFFF vs 0x00000001 -> 1. SLTU same operands -> 0. PASS_B in2=0x12345000 -> 0x12345000. alu_op=15 -> 0.
- Compare 0xFFFFFFFF vs 0x00000001:
  - BLT -> 1, BGE -> 0, BLTU -> 0, BGEU -> 1
  - equal operands 0xA5A5A5A5: BEQ -> 1, BNE -> 0
  - funct3=010 -> 0
- Assert rst_n low asynchronously between clk edges while result_q=0x1234 -> result_q, cond_q, valid_q drop to 0 without a clock edge. After release, the next edge captures new values.
- Back-to-back ops over 3 cycles with valid_in 1,0,1 -> valid_q sequence 1,0,1 one cycle delayed, with result_q tracking each op.
